// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encodings and HD44780 command bytes for the LCD frame writer
package lcd_pkg;

  typedef enum logic [2:0] {PWRUP, INIT, SETADDR, FETCH, WRITE, IDLE} lcd_state_e;
  typedef enum logic [2:0] {X_IDLE, X_SETUP, X_PULSE, X_WAIT, X_DONE} xfer_phase_e;

  localparam logic [7:0] CMD_FUNCSET = 8'h38;
  localparam logic [7:0] CMD_DISPON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_LINE1   = 8'h80;
  localparam logic [7:0] CMD_LINE2   = 8'hC0;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = CMD_FUNCSET;
      2'd1:    init_cmd = CMD_DISPON;
      2'd2:    init_cmd = CMD_ENTRY;
      default: init_cmd = CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_if.sv
// rtl/lcd_if.sv - phrase-bank fetch port plus HD44780 panel bus
interface lcd_if;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       RS;
  logic       RW;
  logic       E;
  logic [7:0] DB;

  modport master (output char_addr, RS, RW, E, DB, input char_data);
  modport slave  (input char_addr, RS, RW, E, DB, output char_data);
endinterface

// File: rtl/lcd_byte_xfer.sv
// rtl/lcd_byte_xfer.sv - one HD44780 byte write: setup, E strobe, post-pulse wait, done pulse
module lcd_byte_xfer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 4,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

  xfer_phase_e phase, phase_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] wait_len;
  logic        rs_q;
  logic [7:0]  db_q;

  // Only the clear command needs the long settle; a data byte of 0x01 is an ordinary character.
  assign wait_len = (!rs_q && db_q == CMD_CLEAR) ? 32'(CLEAR_WAIT_CYC) : 32'(CMD_WAIT_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= X_IDLE;
      cnt   <= '0;
      rs_q  <= 1'b0;
      db_q  <= 8'h00;
    end else begin
      phase <= phase_n;
      cnt   <= cnt_n;
      if (phase == X_IDLE && start) begin
        rs_q <= rs;
        db_q <= data;
      end
    end
  end

  always_comb begin
    phase_n = phase;
    cnt_n   = cnt + 32'd1;
    case (phase)
      X_IDLE: begin
        cnt_n = '0;
        if (start) phase_n = X_SETUP;
      end
      X_SETUP: if (cnt == 32'(SETUP_CYC - 1)) begin
        phase_n = X_PULSE;
        cnt_n   = '0;
      end
      X_PULSE: if (cnt == 32'(E_PULSE_CYC - 1)) begin
        phase_n = X_WAIT;
        cnt_n   = '0;
      end
      X_WAIT: if (cnt == wait_len - 32'd1) begin
        phase_n = X_DONE;
        cnt_n   = '0;
      end
      default: begin
        phase_n = X_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign done   = (phase == X_DONE);
  assign lcd_e  = (phase == X_PULSE);
  assign lcd_rs = rs_q;
  assign lcd_db = db_q;

endmodule

// File: rtl/lcd_frame_writer.sv
// rtl/lcd_frame_writer.sv - power-up init then continuous two-line refresh of a 16x2 HD44780 panel
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 2000000,
  parameter int SETUP_CYC      = 4,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic   clock50MHz,
  input  logic   reset,
  input  logic   refresh_en,
  lcd_if.master  bus,
  output logic   init_done,
  output logic   frame_done
);

  lcd_state_e  state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [1:0]  idx, idx_n;
  logic [4:0]  addr, addr_n;
  logic [7:0]  char_q, char_n;
  logic        issued, issued_n;
  logic        init_done_n, frame_done_n;
  logic        start, x_rs, done;
  logic [7:0]  x_data;
  logic        lcd_rs, lcd_e;
  logic [7:0]  lcd_db;

  lcd_byte_xfer #(
    .SETUP_CYC     (SETUP_CYC),
    .E_PULSE_CYC   (E_PULSE_CYC),
    .CMD_WAIT_CYC  (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_xfer (
    .clk   (clock50MHz),
    .rst_n (reset),
    .start (start),
    .rs    (x_rs),
    .data  (x_data),
    .done  (done),
    .lcd_rs(lcd_rs),
    .lcd_e (lcd_e),
    .lcd_db(lcd_db)
  );

  always_ff @(posedge clock50MHz or negedge reset) begin
    if (!reset) begin
      state      <= PWRUP;
      cnt        <= '0;
      idx        <= '0;
      addr       <= '0;
      char_q     <= 8'h00;
      issued     <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      addr       <= addr_n;
      char_q     <= char_n;
      issued     <= issued_n;
      init_done  <= init_done_n;
      frame_done <= frame_done_n;
    end
  end

  // Byte-issuing states raise start once, then wait on done; issued remembers the handoff.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    idx_n        = idx;
    addr_n       = addr;
    char_n       = char_q;
    issued_n     = issued;
    init_done_n  = init_done;
    frame_done_n = 1'b0;
    start        = 1'b0;
    x_rs         = 1'b0;
    x_data       = 8'h00;
    case (state)
      PWRUP: begin
        if (cnt == 32'(POWERUP_CYC - 1)) begin
          state_n = INIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      INIT: begin
        x_data = init_cmd(idx);
        if (!issued) begin
          start    = 1'b1;
          issued_n = 1'b1;
        end else if (done) begin
          issued_n = 1'b0;
          if (idx == 2'd3) begin
            idx_n       = '0;
            init_done_n = 1'b1;
            state_n     = SETADDR;
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end
      SETADDR: begin
        x_data = (addr == 5'd0) ? CMD_LINE1 : CMD_LINE2;
        if (!issued) begin
          start    = 1'b1;
          issued_n = 1'b1;
        end else if (done) begin
          issued_n = 1'b0;
          cnt_n    = '0;
          state_n  = FETCH;
        end
      end
      FETCH: begin
        if (cnt == 32'd1) begin
          char_n  = bus.char_data;
          cnt_n   = '0;
          state_n = WRITE;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      WRITE: begin
        x_rs   = 1'b1;
        x_data = char_q;
        if (!issued) begin
          start    = 1'b1;
          issued_n = 1'b1;
        end else if (done) begin
          issued_n = 1'b0;
          cnt_n    = '0;
          if (addr == 5'd15) begin
            addr_n  = 5'd16;
            state_n = SETADDR;
          end else if (addr == 5'd31) begin
            addr_n       = 5'd0;
            frame_done_n = 1'b1;
            state_n      = refresh_en ? SETADDR : IDLE;
          end else begin
            addr_n  = addr + 5'd1;
            state_n = FETCH;
          end
        end
      end
      default: begin
        if (refresh_en) state_n = SETADDR;
      end
    endcase
  end

  assign bus.char_addr = addr;
  assign bus.RS        = lcd_rs;
  assign bus.RW        = 1'b0;
  assign bus.E         = lcd_e;
  assign bus.DB        = lcd_db;

endmodule
